// File: rtl/viterbi_acs_ctrl_if.sv
// Signal bundle between the 4-state Viterbi ACS sequencer and the rest of the decoder
// (symbol source, ACS array, survivor memory, traceback unit).
interface viterbi_acs_ctrl_if #(parameter int ADDR_W = 6);
  logic              start;
  logic [ADDR_W:0]   frame_len;
  logic              sym_valid;
  logic [1:0]        sym_data;
  logic              sym_ready;
  logic [1:0]        acs_data_recv;
  logic [27:0]       pm_q;
  logic [3:0]        pm_valid;
  logic [27:0]       acs_pm;
  logic [7:0]        acs_addr;
  logic [3:0]        acs_term;
  logic              surv_we;
  logic [ADDR_W-1:0] surv_addr;
  logic [7:0]        surv_wdata;
  logic              tb_start;
  logic [ADDR_W-1:0] tb_last_addr;
  logic [1:0]        tb_best_state;
  logic              tb_done;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, frame_len, sym_valid, sym_data, acs_pm, acs_addr, acs_term, tb_done,
    output sym_ready, acs_data_recv, pm_q, pm_valid, surv_we, surv_addr, surv_wdata,
           tb_start, tb_last_addr, tb_best_state, busy, frame_done
  );

  modport slave (
    output start, frame_len, sym_valid, sym_data, acs_pm, acs_addr, acs_term, tb_done,
    input  sym_ready, acs_data_recv, pm_q, pm_valid, surv_we, surv_addr, surv_wdata,
           tb_start, tb_last_addr, tb_best_state, busy, frame_done
  );
endinterface

// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer for the 4-state K=3 Viterbi ACS array: owns the path metrics,
// reachability mask and normalisation, writes survivors and launches traceback.
module viterbi_acs_pm_lane #(
  parameter int NORM_BIT = 6
) (
  input  logic [6:0] acs_pm,
  input  logic       acs_term,
  input  logic       valid_nxt,
  input  logic       norm,
  output logic       norm_ok,
  output logic [6:0] pm_nxt
);
  logic [6:0] cand;

  assign cand    = acs_term ? 7'd0 : acs_pm;
  // Unreachable states never veto normalisation.
  assign norm_ok = cand[NORM_BIT] | ~valid_nxt;
  assign pm_nxt  = (norm && valid_nxt) ? (cand & ~(7'd1 << NORM_BIT)) : cand;
endmodule

module viterbi_acs_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int NORM_BIT = 6
) (
  input logic                clk,
  input logic                rst_n,
  viterbi_acs_ctrl_if.master bus
);
  localparam int NUM_LANES = 4;
  localparam int PM_W      = 7;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  typedef enum logic [2:0] {IDLE, RUN, TB_REQ, TB_WAIT, DONE} state_e;

  state_e                         state_q, state_d;
  logic [NUM_LANES-1:0][PM_W-1:0] pm_q, pm_d, pm_nxt;
  logic [NUM_LANES-1:0]           valid_q, valid_d, valid_nxt, norm_ok;
  logic [ADDR_W-1:0]              step_q, step_d, len_m1_q, len_m1_d;
  logic [ADDR_W-1:0]              tb_last_q, tb_last_d;
  logic [1:0]                     tb_best_q, tb_best_d;
  logic                           sym_ready_q, sym_ready_d;
  logic                           tb_start_q, tb_start_d;
  logic                           busy_q, busy_d;
  logic                           frame_done_q, frame_done_d;
  logic                           accept, norm;
  logic [ADDR_W:0]                len_eff;
  logic [1:0]                     best_idx;
  logic [PM_W-1:0]                best_pm;
  logic                           found;

  assign accept = bus.sym_valid & sym_ready_q;

  // Next-state reachability follows the trellis: ns = {b, s[1]}, so ns is
  // reachable from predecessors {ns[0], x}.
  always_comb begin
    for (int s = 0; s < NUM_LANES; s++)
      valid_nxt[s] = valid_q[(s & 1) * 2] | valid_q[(s & 1) * 2 + 1];
  end

  assign norm = &norm_ok;

  for (genvar s = 0; s < NUM_LANES; s++) begin : g_lane
    viterbi_acs_pm_lane #(.NORM_BIT(NORM_BIT)) u_lane (
      .acs_pm    (bus.acs_pm[PM_W*s +: PM_W]),
      .acs_term  (bus.acs_term[s]),
      .valid_nxt (valid_nxt[s]),
      .norm      (norm),
      .norm_ok   (norm_ok[s]),
      .pm_nxt    (pm_nxt[s])
    );
  end

  // Best end state over the metrics about to be written; strict < keeps lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_pm  = '1;
    found    = 1'b0;
    for (int s = 0; s < NUM_LANES; s++) begin
      if (valid_nxt[s] && (!found || pm_nxt[s] < best_pm)) begin
        found    = 1'b1;
        best_pm  = pm_nxt[s];
        best_idx = 2'(s);
      end
    end
  end

  assign len_eff = (bus.frame_len == '0 || bus.frame_len > DEPTH) ? DEPTH : bus.frame_len;

  always_comb begin
    state_d      = state_q;
    pm_d         = pm_q;
    valid_d      = valid_q;
    step_d       = step_q;
    len_m1_d     = len_m1_q;
    tb_last_d    = tb_last_q;
    tb_best_d    = tb_best_q;
    sym_ready_d  = sym_ready_q;
    tb_start_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d     = RUN;
        pm_d        = '0;
        valid_d     = 4'b0001;
        step_d      = '0;
        len_m1_d    = ADDR_W'(len_eff - 1'b1);
        sym_ready_d = 1'b1;
        busy_d      = 1'b1;
      end
      RUN: if (accept) begin
        pm_d    = pm_nxt;
        valid_d = valid_nxt;
        if (step_q == len_m1_q) begin
          state_d     = TB_REQ;
          sym_ready_d = 1'b0;
          tb_start_d  = 1'b1;
          tb_last_d   = len_m1_q;
          tb_best_d   = best_idx;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      TB_REQ:  state_d = TB_WAIT;
      TB_WAIT: if (bus.tb_done) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        sym_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pm_q         <= '0;
      valid_q      <= 4'b0001;
      step_q       <= '0;
      len_m1_q     <= '0;
      tb_last_q    <= '0;
      tb_best_q    <= '0;
      sym_ready_q  <= 1'b0;
      tb_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pm_q         <= pm_d;
      valid_q      <= valid_d;
      step_q       <= step_d;
      len_m1_q     <= len_m1_d;
      tb_last_q    <= tb_last_d;
      tb_best_q    <= tb_best_d;
      sym_ready_q  <= sym_ready_d;
      tb_start_q   <= tb_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sym_ready     = sym_ready_q;
  assign bus.acs_data_recv = bus.sym_data;
  assign bus.pm_q          = pm_q;
  assign bus.pm_valid      = valid_q;
  assign bus.surv_we       = accept;
  assign bus.surv_addr     = step_q;
  assign bus.surv_wdata    = bus.acs_addr;
  assign bus.tb_start      = tb_start_q;
  assign bus.tb_last_addr  = tb_last_q;
  assign bus.tb_best_state = tb_best_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Randomised bench for viterbi_acs_ctrl: an ideal/random ACS driver plus a
// step-level metric model derived from the frame rules.
module tb_viterbi_acs_ctrl;
  localparam int ADDR_W    = 6;
  localparam int NORM_BIT  = 6;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  viterbi_acs_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  viterbi_acs_ctrl #(.ADDR_W(ADDR_W), .NORM_BIT(NORM_BIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  int              m_pm [4];
  logic [3:0]      m_valid;
  int              m_step;
  logic [6:0]      tbl_pm [4][4];
  logic [3:0]      tbl_term [4];
  bit              tbl_en [4];
  logic [27:0]     drv_pm;
  logic [7:0]      drv_addr;
  logic [3:0]      drv_term;
  logic [1:0]      last_best;
  logic [ADDR_W-1:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] pack_pm();
    logic [27:0] r = '0;
    for (int s = 0; s < 4; s++) r[7*s +: 7] = 7'(m_pm[s]);
    return r;
  endfunction

  function automatic logic [1:0] model_best();
    int bi = -1;
    for (int s = 0; s < 4; s++)
      if (m_valid[s] && (bi < 0 || m_pm[s] < m_pm[bi])) bi = s;
    return 2'(bi);
  endfunction

  task automatic set_tbl(input int st, input int p0, input int p1, input int p2, input int p3,
                         input logic [3:0] term);
    tbl_en[st] = 1;
    tbl_pm[st][0] = 7'(p0); tbl_pm[st][1] = 7'(p1);
    tbl_pm[st][2] = 7'(p2); tbl_pm[st][3] = 7'(p3);
    tbl_term[st] = term;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < 4; i++) tbl_en[i] = 0;
  endtask

  // amode 1: random ACS outputs; otherwise an ideal (7,5) ACS driven from the model metrics.
  task automatic drive_acs(input int amode, input logic [1:0] sym);
    drv_pm = '0; drv_addr = '0; drv_term = '0;
    for (int ns = 0; ns < 4; ns++) begin
      int best = -1;
      int bp = 0;
      if (m_step < 4 && tbl_en[m_step]) begin
        drv_pm[7*ns +: 7] = tbl_pm[m_step][ns];
        drv_term[ns] = tbl_term[m_step][ns];
        drv_addr[2*ns +: 2] = 2'(ns);
      end else if (amode == 1) begin
        drv_pm[7*ns +: 7] = 7'($urandom_range(0, 127));
        drv_term[ns] = ($urandom_range(0, 7) == 0);
        drv_addr[2*ns +: 2] = 2'($urandom_range(0, 3));
      end else begin
        for (int x = 0; x < 2; x++) begin
          int pr = ((ns & 1) << 1) | x;
          int b  = ns >> 1;
          int c0 = b ^ (pr >> 1) ^ (pr & 1);
          int c1 = b ^ (pr & 1);
          int bm = int'(int'(sym[1]) != c0) + int'(int'(sym[0]) != c1);
          if (m_valid[pr] && (best < 0 || m_pm[pr] + bm < best)) begin
            best = m_pm[pr] + bm;
            bp = pr;
          end
        end
        if (best < 0) drv_term[ns] = 1'b1;
        else begin
          drv_pm[7*ns +: 7] = 7'((best > 127) ? 127 : best);
          drv_addr[2*ns +: 2] = 2'(bp);
        end
      end
    end
    bus.acs_pm = drv_pm; bus.acs_addr = drv_addr; bus.acs_term = drv_term;
  endtask

  task automatic model_accept();
    int nw [4];
    logic [3:0] nv;
    bit norm = 1;
    nv = (m_step == 0) ? 4'b0101 : 4'b1111;
    for (int s = 0; s < 4; s++) nw[s] = drv_term[s] ? 0 : int'(drv_pm[7*s +: 7]);
    for (int s = 0; s < 4; s++) if (nv[s] && nw[s] < (1 << NORM_BIT)) norm = 0;
    for (int s = 0; s < 4; s++) if (norm && nv[s]) nw[s] -= (1 << NORM_BIT);
    for (int s = 0; s < 4; s++) m_pm[s] = nw[s];
    m_valid = nv;
  endtask

  // vmode: 0 always valid, 1 random valid, 2 repeating 1,0,0,1. amode: 0 ideal zero syms, 1 random ACS, 2 ideal random syms.
  task automatic run_frame(input int flen, input int vmode, input int amode);
    int eff = (flen == 0 || flen > MEM_DEPTH) ? MEM_DEPTH : flen;
    int cyc = 0;
    bit fin = 0;
    int w;
    logic [ADDR_W-1:0] last_exp;
    @(negedge clk);
    bus.start = 1'b1; bus.frame_len = 7'(flen); bus.sym_valid = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) m_pm[s] = 0;
    m_valid = 4'b0001; m_step = 0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_ready", 32'(bus.sym_ready), 1);
    chk("start_pm", 32'(bus.pm_q), 0);
    chk("start_mask", 32'(bus.pm_valid), 32'h1);
    while (!fin && cyc < eff * 4 + 16) begin
      logic v;
      logic [1:0] sd;
      @(negedge clk);
      bus.start = 1'b0;
      case (vmode)
        0:       v = 1'b1;
        2:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      sd = (amode == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      bus.sym_valid = v; bus.sym_data = sd;
      drive_acs(amode, sd);
      #1;
      chk("ready", 32'(bus.sym_ready), 1);
      chk("recv", 32'(bus.acs_data_recv), 32'(sd));
      chk("surv_we", 32'(bus.surv_we), 32'(v));
      chk("surv_addr", 32'(bus.surv_addr), 32'(m_step));
      if (v) chk("surv_wdata", 32'(bus.surv_wdata), 32'(drv_addr));
      @(posedge clk); #1;
      cyc++;
      if (v) begin
        model_accept();
        chk("pm", 32'(bus.pm_q), 32'(pack_pm()));
        chk("mask", 32'(bus.pm_valid), 32'(m_valid));
        if (m_step == eff - 1) fin = 1; else m_step++;
      end
      if (vmode == 2 && cyc == 4) chk("bp_step", 32'(bus.surv_addr), 2);
    end
    chk("frame_timeout", 32'(fin), 1);
    last_exp  = ADDR_W'(eff - 1);
    last_best = bus.tb_best_state;
    last_addr = bus.tb_last_addr;
    chk("tb_start", 32'(bus.tb_start), 1);
    chk("tb_last", 32'(bus.tb_last_addr), 32'(last_exp));
    chk("tb_best", 32'(bus.tb_best_state), 32'(model_best()));
    chk("tb_ready", 32'(bus.sym_ready), 0);
    w = $urandom_range(1, 3);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      bus.start = (i == w - 1); bus.frame_len = 7'($urandom_range(0, 127)); bus.sym_valid = 1'b1;
      @(posedge clk); #1;
      chk("tb_pulse", 32'(bus.tb_start), 0);
      chk("wait_last", 32'(bus.tb_last_addr), 32'(last_exp));
      chk("wait_best", 32'(bus.tb_best_state), 32'(model_best()));
      chk("wait_done", 32'(bus.frame_done), 0);
      chk("wait_busy", 32'(bus.busy), 1);
      chk("wait_we", 32'(bus.surv_we), 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.sym_valid = 1'b0; bus.tb_done = 1'b1;
    @(posedge clk); #1;
    chk("frame_done", 32'(bus.frame_done), 1);
    chk("pm_keep", 32'(bus.pm_q), 32'(pack_pm()));
    @(negedge clk);
    bus.tb_done = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.frame_done), 0);
    chk("idle", 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.frame_len = '0; bus.sym_valid = 1'b0; bus.sym_data = '0;
    bus.acs_pm = '0; bus.acs_addr = '0; bus.acs_term = '0; bus.tb_done = 1'b0;
    clr_tbl();
    for (int s = 0; s < 4; s++) m_pm[s] = 0;
    m_valid = 4'b0001; m_step = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pm", 32'(bus.pm_q), 0);
    chk("rst_mask", 32'(bus.pm_valid), 32'h1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.sym_ready), 0);
    @(negedge clk); rst_n = 1'b1;

    // Abort mid-frame after three accepts.
    @(negedge clk); bus.start = 1'b1; bus.frame_len = 7'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.sym_valid = 1'b1; bus.sym_data = 2'b11;
      drive_acs(2, 2'b11);
    end
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    rst_n = 1'b0; bus.sym_valid = 1'b0;
    #1;
    chk("abort_pm", 32'(bus.pm_q), 0);
    chk("abort_mask", 32'(bus.pm_valid), 32'h1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_addr", 32'(bus.surv_addr), 0);
    @(posedge clk); #1;
    chk("abort_tbs", 32'(bus.tb_start), 0);
    chk("abort_fd", 32'(bus.frame_done), 0);
    @(negedge clk); rst_n = 1'b1;

    run_frame(4, 0, 0);
    chk("zero_best", 32'(last_best), 0);
    chk("zero_last", 32'(last_addr), 3);

    set_tbl(2, 64, 70, 65, 100, 4'b0000);
    run_frame(3, 0, 2);
    chk("norm_pm", 32'(bus.pm_q), 32'({7'd36, 7'd1, 7'd6, 7'd0}));
    set_tbl(2, 63, 70, 65, 100, 4'b0000);
    run_frame(3, 0, 2);
    chk("no_norm_pm", 32'(bus.pm_q), 32'({7'd100, 7'd65, 7'd70, 7'd63}));
    set_tbl(2, 5, 3, 3, 9, 4'b0000);
    run_frame(3, 0, 2);
    chk("tie_best", 32'(last_best), 1);
    clr_tbl();

    set_tbl(0, 10, 20, 30, 40, 4'b0100);
    run_frame(1, 0, 2);
    chk("term_pm2", 32'(bus.pm_q[20:14]), 0);
    chk("term_noX", 32'($isunknown({bus.pm_q, bus.pm_valid, bus.tb_best_state})), 0);
    chk("term_best", 32'(last_best), 2);
    clr_tbl();

    run_frame(6, 2, 2);

    run_frame(0, 1, 1);
    chk("len0_last", 32'(last_addr), 32'(MEM_DEPTH - 1));
    run_frame(MEM_DEPTH + 5, 1, 2);
    chk("lenbig_last", 32'(last_addr), 32'(MEM_DEPTH - 1));

    repeat (6) run_frame($urandom_range(1, 20), 1, $urandom_range(1, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/viterbi_acs_ctrl.md
Name: viterbi_acs_ctrl

Overview:
Sequencer for the 4-state (K=3, rate-1/2) Viterbi add-compare-select array.
- Owns the four 7-bit path-metric registers and feeds them to the four combinational ACS units.
- Drives the per-state reachability mask that the top level converts into ACS term inputs, and normalises metrics.
- Writes per-step survivor decisions to survivor memory, then hands the frame to the traceback unit with the best end state.

Parameters:
ADDR_W, 6, survivor memory address width; MEM_DEPTH = 2**ADDR_W trellis steps per frame max
NORM_BIT, 6, metric bit tested/cleared for normalisation (must be < 7)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin frame (honoured only in IDLE)
frame_len  in  ADDR_W+1  symbols in frame, sampled on start
sym_valid  in  1  received symbol valid
sym_data  in  2  received code pair
sym_ready  out  1  controller accepts symbol this cycle
acs_data_recv  out  2  symbol to all ACS units (= sym_data)
pm_q  out  28  current metrics, state s at [7s+6:7s]
pm_valid  out  4  reachable-state mask; top level derives term_x = ~pm_valid[pred]
acs_pm  in  28  ACS PMout per state, same packing
acs_addr  in  8  ACS addr_out per state, [2s+1:2s]
acs_term  in  4  ACS term_out per state
surv_we  out  1  survivor write strobe
surv_addr  out  ADDR_W  survivor write address
surv_wdata  out  8  = acs_addr
tb_start  out  1  one-cycle traceback request
tb_last_addr  out  ADDR_W  last written survivor address
tb_best_state  out  2  argmin of final metrics
tb_done  in  1  traceback complete
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset, async, all outputs low except as listed: state=IDLE, pm_q=0, pm_valid=4'b0001, step=0, surv_addr=0.
- FSM states: IDLE, RUN, TB_REQ, TB_WAIT, DONE.
- IDLE:
  - On start: latch len = (frame_len==0 || frame_len>MEM_DEPTH) ? MEM_DEPTH : frame_len.
  - Also on start: pm_q=0, pm_valid=4'b0001, step=0, then go to RUN.
  - start is ignored in all other states.
- RUN:
  - sym_ready=1; acs_data_recv=sym_data combinationally.
  - Accept on sym_valid&&sym_ready. ACS is combinational, so the accept edge registers the new metrics and writes the survivor in the same cycle.
- Accept edge, metric update:
  - surv_we=1 (combinational, qualified by accept); surv_addr=step; surv_wdata=acs_addr.
  - pm_q[s] <= acs_pm[s] for states with acs_term[s]=0. For states with acs_term[s]=1, pm_q[s] <= 0 (never X).
- Accept edge, mask and normalisation:
  - pm_valid progression: 0001 -> 0101 after step 0 -> 1111 after step 1, then constant.
  - If bit NORM_BIT is set in every valid state's new metric, clear that bit in all valid metrics in the same write. This subtracts 2**NORM_BIT, so no wrap occurs.
- Last symbol: when step==len-1 on accept, go to TB_REQ; otherwise step++.
- TB_REQ, single cycle:
  - tb_start=1; tb_last_addr=len-1.
  - tb_best_state = index of minimum valid pm_q; ties resolve to the lowest index.
  - Then go to TB_WAIT.
- TB_WAIT: tb_last_addr and tb_best_state held stable; on tb_done go to DONE. A tb_done arriving in any other state is ignored.
- DONE: frame_done=1 for one cycle, then IDLE. Metrics are retained until the next start.
- sym_ready=0 outside RUN, so there are no accepts outside RUN.
- rst_n low at any time aborts the frame immediately with no tb_start or frame_done. Survivor contents are left undefined.
- Latency:
  - start to first sym_ready: 1 cycle.
  - Last accept to tb_start: 1 cycle.
  - tb_done to frame_done: 1 cycle.

Test Plan:
1. Reset mid-RUN (after 3 accepts) -> next cycle state IDLE, pm_q=0, pm_valid=0001, busy=0, no tb_start/frame_done.
2. start, frame_len=4, all-zero symbols with an ideal ACS model, sym_valid always 1:
   - surv_addr 0..3 with surv_we on 4 consecutive cycles.
   - pm_valid 0001 -> 0101 -> 1111.
   - tb_start one cycle later with tb_last_addr=3, tb_best_state=0.
   - tb_done -> frame_done 1 cycle later.
3. Normalisation: force acs_pm to 64,70,65,100 with all valid -> pm_q becomes 0,6,1,36. With acs_pm 63,70,65,100 -> no subtraction.
4. Tie-break and term:
   - Final metrics 5,3,3,9 -> tb_best_state=1.
   - acs_term[2]=1 at step 0 -> pm_q[2]=0, no X on outputs.
5. Backpressure: sym_valid toggling 1,0,0,1 -> only valid cycles write, step increments exactly twice.
6. frame_len=0 and frame_len=MEM_DEPTH+5 -> both run MEM_DEPTH steps, tb_last_addr=MEM_DEPTH-1. start pulsed during TB_WAIT -> ignored.
